serial_adder: RTL and testbench



---
 rtl/arith_pkg.sv | 15 +
 rtl/adder_digit.sv | 28 ++
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM encodings and counter sizing for the serial arithmetic units
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_digit.sv
// rtl/adder_digit.sv - combinational DIGIT-bit ripple adder, exposes carry into its top bit
module adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = x[i] ^ y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle add/subtract, DIGIT bits per clock, start/busy/done handshake
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_cmsb;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(NDIG - 1));

    adder_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x    (r_a[DIGIT-1:0]),
        .y    (r_b[DIGIT-1:0]),
        .ci   (r_carry),
        .s    (w_s),
        .co   (w_co),
        .c_msb(w_cmsb)
    );

    // Digits enter at the MSB end so after NDIG shifts the LSB digit lands at bit 0.
    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_acc   <= w_acc_next;
            r_carry <= w_co;
            r_cnt   <= r_cnt + 1'b1;
            // Visible results move only here so they stay stable while running.
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_co;
                r_ovf  <= w_co ^ w_cmsb;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at (8,1), (8,4) and (16,4)
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", nm, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_i
        localparam int W = (g == 2) ? 16 : 8;
        localparam int D = (g == 0) ? 1 : 4;
        localparam int N = W / D;

        logic         rst, start, sub, cin;
        logic [W-1:0] a, b, sum;
        logic         busy, done, cout, ovf;
        logic [W+1:0] q[$];
        logic [W-1:0] hold = '0;
        int           bc = 0;
        bit           fin = 1'b0;

        serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start),
            .sub  (sub),
            .a    (a),
            .b    (b),
            .cin  (cin),
            .busy (busy),
            .done (done),
            .sum  (sum),
            .cout (cout),
            .ovf  (ovf)
        );

        // Reference: unsigned modulo arithmetic for sum/cout, true signed range test for ovf.
        function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x,
                                               input logic [W-1:0] y, input logic c);
            longint ux, uy, full, sx, sy, tr;
            logic   ov;
            ux = longint'(x);
            uy = longint'(y);
            sx = x[W-1] ? ux - (longint'(1) << W) : ux;
            sy = y[W-1] ? uy - (longint'(1) << W) : uy;
            if (s) begin
                full = ux + ((longint'(1) << W) - uy);
                tr   = sx - sy;
            end else begin
                full = ux + uy + longint'(c);
                tr   = sx + sy + longint'(c);
            end
            ov = (tr > (longint'(1) << (W - 1)) - 1) || (tr < -(longint'(1) << (W - 1)));
            return {full[W-1:0], full[W], ov};
        endfunction

        // Caller is at a negedge with the DUT idle or in DONE.
        task automatic op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
            start = 1'b1; sub = s; a = x; b = y; cin = c;
            q.push_back(model(s, x, y, c));
            @(posedge clk);
            #1 start = 1'b0;
        endtask

        task automatic wait_done();
            for (int k = 0; k < 4 * N + 20; k++) begin
                @(negedge clk);
                if (done) break;
            end
            chk("done_seen", g, 32'(done), 32'd1);
        endtask

        always @(negedge clk) begin
            logic [W+1:0] e;
            if (busy) begin
                bc++;
                chk("sum_stable_in_run", g, 32'(sum), 32'(hold));
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", g, 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sum", g, 32'(sum), 32'(e[W+1:2]));
                    chk("cout", g, 32'(cout), 32'(e[1]));
                    chk("ovf", g, 32'(ovf), 32'(e[0]));
                    chk("busy_cycles", g, 32'(bc), 32'(N));
                    hold = e[W+1:2];
                end
                bc = 0;
            end
        end

        initial begin
            logic [15:0] va[6] = '{16'h000F, 16'h007F, 16'h00FF, 16'h00FF, 16'h0005, 16'h0080};
            logic [15:0] vb[6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
            logic        vc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            logic        vs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            int          kabort;
            rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
            repeat (2) @(negedge clk);
            chk("reset_busy", g, 32'(busy), 32'd0);
            chk("reset_done", g, 32'(done), 32'd0);
            chk("reset_sum", g, 32'(sum), 32'd0);
            chk("reset_cout", g, 32'(cout), 32'd0);
            chk("reset_ovf", g, 32'(ovf), 32'd0);
            rst = 1'b0;
            @(negedge clk);

            for (int i = 0; i < 6; i++) begin
                op(vs[i], W'(va[i]), W'(vb[i]), vc[i]);
                wait_done();
                @(negedge clk);
            end
            op(1'b0, W'(16'h1234), W'(16'h0FCC), 1'b0);
            wait_done();
            @(negedge clk);

            // Start while running must be ignored, then back-to-back from DONE.
            op(1'b0, W'(16'h000F), W'(16'h0001), 1'b0);
            @(negedge clk);
            start = 1'b1; a = W'(16'h0011); b = W'(16'h0011); cin = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            wait_done();
            op(1'b0, W'(16'h0002), W'(16'h0003), 1'b0);
            chk("b2b_busy", g, 32'(busy), 32'd1);
            wait_done();
            @(negedge clk);

            // Abort mid-run: rst sampled on the 4th RUN edge (earlier for short ops).
            kabort = (N > 4) ? 4 : N - 1;
            start = 1'b1; sub = 1'b0; a = W'(16'h00AA); b = W'(16'h0055); cin = 1'b0;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (kabort - 1) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            hold = '0;
            bc = 0;
            chk("abort_busy", g, 32'(busy), 32'd0);
            chk("abort_done", g, 32'(done), 32'd0);
            chk("abort_sum", g, 32'(sum), 32'd0);
            chk("abort_cout", g, 32'(cout), 32'd0);
            chk("abort_ovf", g, 32'(ovf), 32'd0);
            repeat (N + 3) @(negedge clk);

            for (int i = 0; i < 40; i++) begin
                op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
                wait_done();
                if ($urandom_range(0, 1) == 0) @(negedge clk);
            end
            repeat (2) @(negedge clk);
            chk("queue_drained", g, 32'(q.size()), 32'd0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 30000; t++) begin
            @(posedge clk);
            if (g_i[0].fin && g_i[1].fin && g_i[2].fin) break;
        end
        chk("all_finished", 0, 32'(g_i[0].fin && g_i[1].fin && g_i[2].fin), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
